xbs_bram: RTL and testbench

//  XBUS slave (responder) for the bitstream/readback memory: answers the master-side

---
 rtl/xbs_bram_pkg.sv | 20 ++
 rtl/xbs_bram_ram.sv | 33 +++
 rtl/xbs_bram.sv | 111 +++++++++++
 tb/tb_xbs_bram.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbs_bram_pkg.sv
// Shared XBUS slave definitions: bus widths, slave state encoding and sizing helpers.
// Other XBUS slaves import this package so their state encodings match.
package xbs_bram_pkg;

    localparam int XBUS_DW  = 32;
    localparam int XBUS_AW  = 32;
    localparam int XBUS_BEW = XBUS_DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } xbs_state_e;

    // Wait counter must hold WAIT_STATES; never narrower than one bit.
    function automatic int cnt_width(input int ws);
        return (ws < 1) ? 1 : $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/xbs_bram_ram.sv
// Single-port synchronous RAM, DEPTH x 32 bits, per-byte write enables, registered read.
// Contents are intentionally not reset.
module xbs_bram_ram
    import xbs_bram_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                en,
    input  logic [XBUS_BEW-1:0] we,
    input  logic [AW-1:0]       addr,
    input  logic [XBUS_DW-1:0]  wdata,
    output logic [XBUS_DW-1:0]  rdata
);

    logic [XBUS_DW-1:0] mem [DEPTH];
    logic [XBUS_DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < XBUS_BEW; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/xbs_bram.sv
// XBUS slave front-end for an on-chip word RAM: wait-state FSM, range decode, abort on
// select withdrawal, and output gating so sl_data is zero whenever it is not valid.
module xbs_bram
    import xbs_bram_pkg::*;
#(
    parameter logic [XBUS_AW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                 DEPTH       = 1024,
    parameter int                 WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                xbs_select,
    input  logic [XBUS_AW-1:0]  xbs_addr,
    input  logic [XBUS_DW-1:0]  xbs_data,
    input  logic                xbs_rnw,
    input  logic [XBUS_BEW-1:0] xbs_be,
    output logic                sl_ack,
    output logic [XBUS_DW-1:0]  sl_data,
    output logic                sl_err
);

    localparam int CW = cnt_width(WAIT_STATES);
    localparam int AW = $clog2(DEPTH);

    xbs_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic               err_q, err_d;
    logic [XBUS_AW-1:0] off;
    logic               in_range;
    logic               enter_ack;
    logic               ram_en;
    logic [XBUS_BEW-1:0] ram_we;
    logic [XBUS_DW-1:0] ram_rdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        err_d     = err_q;
        enter_ack = 1'b0;
        // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
        off       = xbs_addr - BASE_ADDR;
        in_range  = (off < XBUS_AW'(DEPTH));

        case (state_q)
            ST_IDLE: begin
                if (xbs_select) begin
                    cnt_d = CW'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!xbs_select) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d   = ST_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Bus signals are consumed only on the edge that enters ACK.
        if (enter_ack) begin
            rd_d  = xbs_rnw;
            err_d = !in_range;
        end
        ram_en = enter_ack && in_range;
        ram_we = (ram_en && !xbs_rnw) ? xbs_be : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    xbs_bram_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (off[AW-1:0]),
        .wdata (xbs_data),
        .rdata (ram_rdata)
    );

    assign sl_ack  = (state_q == ST_ACK);
    assign sl_err  = sl_ack && err_q;
    assign sl_data = (sl_ack && rd_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_xbs_bram.sv
// Bench for xbs_bram: two instances (2 and 3 wait states) driven by directed and random
// transfers, checked against a word-array model and the expected ack latency.
module tb_xbs_bram;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel_a, sel_b;
    logic [31:0] addr, wdata;
    logic        rnw;
    logic [3:0]  be;
    logic        ack_a, err_a, ack_b, err_b;
    logic [31:0] data_a, data_b;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] mdl [2][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xbs_bram #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(2)) dut_a (
        .clk(clk), .rstn(rstn), .xbs_select(sel_a), .xbs_addr(addr), .xbs_data(wdata),
        .xbs_rnw(rnw), .xbs_be(be), .sl_ack(ack_a), .sl_data(data_a), .sl_err(err_a)
    );

    xbs_bram #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3)) dut_b (
        .clk(clk), .rstn(rstn), .xbs_select(sel_b), .xbs_addr(addr), .xbs_data(wdata),
        .xbs_rnw(rnw), .xbs_be(be), .sl_ack(ack_b), .sl_data(data_b), .sl_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input int d, input logic v);
        if (d == 0) sel_a = v;
        else        sel_b = v;
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? ack_a : ack_b;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? err_a : err_b;
    endfunction

    function automatic logic [31:0] get_data(input int d);
        return (d == 0) ? data_a : data_b;
    endfunction

    // One complete master transfer; ack must arrive exactly WS+1 cycles after accept.
    task automatic xfer(input int d, input logic rd, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] ben,
                        output logic [31:0] rdat, output int ack_cyc);
        int          ws;
        logic [31:0] off;
        logic        inr;
        logic [31:0] exp_d;
        ws    = (d == 0) ? 2 : 3;
        off   = a - BASE;
        inr   = (off < DEPTH);
        exp_d = (rd && inr) ? mdl[d][off[3:0]] : 32'h0;
        @(posedge clk); #1;
        addr = a; wdata = dat; rnw = rd; be = ben;
        set_sel(d, 1'b1);
        for (int k = 0; k <= ws; k++) begin
            @(negedge clk);
            chk("ack_early", {31'b0, get_ack(d)}, 32'h0);
        end
        @(negedge clk);
        ack_cyc = cyc;
        rdat    = get_data(d);
        chk("ack_latency", {31'b0, get_ack(d)}, 32'h1);
        chk("err_flag", {31'b0, get_err(d)}, {31'b0, !inr});
        chk("rd_data", rdat, exp_d);
        if (!rd && inr) begin
            for (int i = 0; i < 4; i++)
                if (ben[i]) mdl[d][off[3:0]][8*i +: 8] = dat[8*i +: 8];
        end
        @(posedge clk); #1;
        set_sel(d, 1'b0);
        @(negedge clk);
        chk("ack_single", {31'b0, get_ack(d)}, 32'h0);
        chk("data_gated", get_data(d), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int          ac;
        int          prev_ac;
        logic [31:0] burst [8];

        rstn = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
        addr = '0; wdata = '0; rnw = 1'b1; be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack_a", {31'b0, ack_a}, 32'h0);
        chk("rst_err_a", {31'b0, err_a}, 32'h0);
        chk("rst_data_a", data_a, 32'h0);
        chk("rst_ack_b", {31'b0, ack_b}, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Give every word a known value in both instances.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                xfer(d, 1'b0, BASE + i, $urandom, 4'hF, rd, ac);

        // Latency and readback with 2 wait states.
        xfer(0, 1'b0, BASE + 5, 32'h1234_5678, 4'hF, rd, ac);
        xfer(0, 1'b1, BASE + 5, 32'h0, 4'h0, rd, ac);
        chk("t2_readback", rd, 32'h1234_5678);

        // Byte-enable merge.
        xfer(0, 1'b0, BASE + 9, 32'hAABB_CCDD, 4'hF, rd, ac);
        xfer(0, 1'b0, BASE + 9, 32'h1122_3344, 4'b0101, rd, ac);
        xfer(0, 1'b0, BASE + 9, 32'hFFFF_FFFF, 4'b0000, rd, ac);
        xfer(0, 1'b1, BASE + 9, 32'h0, 4'h0, rd, ac);
        chk("t3_merge", rd, 32'hAA22_CC44);

        // Out-of-range accesses: error ack, no aliasing into the array.
        xfer(0, 1'b1, BASE + DEPTH, 32'h0, 4'h0, rd, ac);
        xfer(0, 1'b1, BASE - 1, 32'h0, 4'h0, rd, ac);
        xfer(0, 1'b0, BASE + DEPTH, 32'h5555_AAAA, 4'hF, rd, ac);
        xfer(0, 1'b0, BASE - 1, 32'h6666_9999, 4'hF, rd, ac);
        xfer(0, 1'b1, BASE + 0, 32'h0, 4'h0, rd, ac);
        xfer(0, 1'b1, BASE + DEPTH - 1, 32'h0, 4'h0, rd, ac);

        // Abort: select withdrawn after two cycles on the 3-wait-state instance.
        @(posedge clk); #1;
        addr = BASE + 3; wdata = 32'hDEAD_BEEF; rnw = 1'b0; be = 4'hF;
        sel_b = 1'b1;
        @(negedge clk);
        chk("abort_ack0", {31'b0, ack_b}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_ack1", {31'b0, ack_b}, 32'h0);
        @(posedge clk); #1;
        sel_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_ack", {31'b0, ack_b}, 32'h0);
        end
        xfer(1, 1'b1, BASE + 3, 32'h0, 4'h0, rd, ac);

        // Reset mid-WAIT loses the write and clears outputs at once.
        @(posedge clk); #1;
        addr = BASE + 7; wdata = 32'hCAFE_F00D; rnw = 1'b0; be = 4'hF;
        sel_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("t1_ack", {31'b0, ack_a}, 32'h0);
        chk("t1_err", {31'b0, err_a}, 32'h0);
        chk("t1_data", data_a, 32'h0);
        @(posedge clk); #1;
        sel_a = 1'b0; rstn = 1'b1;
        xfer(0, 1'b1, BASE + 7, 32'h0, 4'h0, rd, ac);

        // Reset during the ack cycle of a read drops ack and data immediately.
        @(posedge clk); #1;
        addr = BASE + 5; rnw = 1'b1; be = 4'h0;
        sel_a = 1'b1;
        repeat (4) @(negedge clk);
        chk("ackrst_pre", {31'b0, ack_a}, 32'h1);
        rstn = 1'b0;
        #1;
        chk("ackrst_ack", {31'b0, ack_a}, 32'h0);
        chk("ackrst_data", data_a, 32'h0);
        @(posedge clk); #1;
        sel_a = 1'b0; rstn = 1'b1;

        // Held select is re-accepted in the IDLE cycle after ack.
        @(posedge clk); #1;
        addr = BASE + 2; rnw = 1'b1; be = 4'h0;
        sel_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("held_ack", {31'b0, ack_a}, {31'b0, (k == 3 || k == 7)});
            chk("held_data", data_a, (k == 3 || k == 7) ? mdl[0][2] : 32'h0);
        end
        @(posedge clk); #1;
        sel_a = 1'b0;

        // Random mix across both instances, including just-outside addresses.
        for (int n = 0; n < 40; n++) begin
            int d;
            d = $urandom_range(0, 1);
            xfer(d, 1'($urandom), BASE - 2 + $urandom_range(0, DEPTH + 3),
                 $urandom, 4'($urandom), rd, ac);
        end

        // Burst write then burst read, as the readback master issues them.
        prev_ac = -100;
        for (int i = 0; i < 8; i++) begin
            burst[i] = $urandom;
            xfer(0, 1'b0, BASE + i, burst[i], 4'hF, rd, ac);
            chk("burst_gap", {31'b0, (ac - prev_ac) >= 4}, 32'h1);
            prev_ac = ac;
        end
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b1, BASE + i, 32'h0, 4'h0, rd, ac);
            chk("burst_read", rd, burst[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
